// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU load/store front end for a word-wide data memory with byte/half read-modify-write
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_ena,
  output logic        dm_wena,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  logic [2:0]  state;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [12:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        bad;
  logic        accept;
  logic        mem_st;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;
  assign req_ready  = state == IDLE;
  assign accept     = req_valid && req_ready;
  assign mem_st     = state == LOAD || state == RMW_RD || state == WRITE;
  assign dm_ena     = mem_st;
  assign dm_addr    = mem_st ? addr_q[12:2] : 11'd0;
  assign dm_wena    = state == WRITE && rst_n;
  assign dm_wdata   = state == WRITE ? wdata_q : 32'd0;
  assign resp_valid = state == DONE;
  assign resp_err   = resp_valid && err_q;
  // request legality, load lane extraction/extension and store lane merge
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_addr[31:13] != 19'd0;
    lane_b = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = dm_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = size_q == 2'b00 ? {{24{signed_q && lane_b[7]}}, lane_b} :
               size_q == 2'b01 ? {{16{signed_q && lane_h[15]}}, lane_h} : dm_rdata;
    merged = dm_rdata;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
  // sequencer: latch on acceptance, walk the access flow, register load and merge results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      addr_q     <= 13'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          size_q   <= req_size;
          signed_q <= req_signed;
          addr_q   <= req_addr[12:0];
          wdata_q  <= req_wdata;
          err_q    <= bad;
          state    <= bad ? DONE : !req_we ? LOAD : req_size == 2'b10 ? WRITE : RMW_RD;
        end
        LOAD: begin
          resp_rdata <= load_val;
          state      <= DONE;
        end
        RMW_RD: begin
          wdata_q <= merged;
          state   <= WRITE;
        end
        WRITE:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven directed checks of dmem_ctrl against a falling-edge-write memory model
module tb_dmem_ctrl;
  logic        clk = 0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_ena, dm_wena;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [31:0] mem [0:2047];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          idx;
    logic [31:0] mval;
  } vec_t;
  vec_t v [20];

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_ena(dm_ena),
    .dm_wena(dm_wena), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (dm_wena) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = dm_ena ? mem[dm_addr] : 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int n);
    int lat, wcnt, ecnt;
    logic [10:0] wa;
    logic [31:0] wd;
    string p;
    p = $sformatf("v%0d", n);
    chk({p, " ready_before"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_we = t.we; req_size = t.size; req_signed = t.sgn;
    req_addr = t.addr; req_wdata = t.wdata;
    wcnt = 0; ecnt = 0; wa = 0; wd = 0;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (dm_ena) ecnt++;
      if (dm_wena) begin wcnt++; wa = dm_addr; wd = dm_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    chk({p, " latency"}, lat, t.lat);
    chk({p, " err"}, {31'd0, resp_err}, {31'd0, t.err});
    chk({p, " rdata"}, resp_rdata, t.rdata);
    chk({p, " ena_seen"}, {31'd0, ecnt != 0}, {31'd0, !t.err});
    chk({p, " wena_cycles"}, wcnt, (t.we && !t.err) ? 1 : 0);
    if (t.we && !t.err) begin
      chk({p, " wr_addr"}, {21'd0, wa}, t.idx);
      chk({p, " wr_data"}, wd, t.mval);
    end
    @(posedge clk); #1;
    chk({p, " ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({p, " valid_after"}, {30'd0, resp_valid, resp_err}, 32'd0);
    chk({p, " mem"}, mem[t.idx], t.mval);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 2, 1'b0, 32'h00000000, 4,    32'hDEADBEEF};
    v[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        2, 1'b0, 32'hDEADBEEF, 4,    32'hDEADBEEF};
    v[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 2, 1'b0, 32'hDEADBEEF, 4,    32'h11223344};
    v[3]  = '{1'b1, 2'b00, 1'b0, 32'h12,   32'h123456AA, 3, 1'b0, 32'hDEADBEEF, 4,    32'h11AA3344};
    v[4]  = '{1'b0, 2'b00, 1'b1, 32'h12,   32'h0,        2, 1'b0, 32'hFFFFFFAA, 4,    32'h11AA3344};
    v[5]  = '{1'b0, 2'b00, 1'b0, 32'h12,   32'h0,        2, 1'b0, 32'h000000AA, 4,    32'h11AA3344};
    v[6]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        2, 1'b0, 32'h000011AA, 4,    32'h11AA3344};
    v[7]  = '{1'b1, 2'b01, 1'b0, 32'h10,   32'hCAFE8001, 3, 1'b0, 32'h000011AA, 4,    32'h11AA8001};
    v[8]  = '{1'b0, 2'b01, 1'b1, 32'h10,   32'h0,        2, 1'b0, 32'hFFFF8001, 4,    32'h11AA8001};
    v[9]  = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        2, 1'b0, 32'h00008001, 4,    32'h11AA8001};
    v[10] = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        2, 1'b0, 32'h00000011, 4,    32'h11AA8001};
    v[11] = '{1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        2, 1'b0, 32'hFFFFFF80, 4,    32'h11AA8001};
    v[12] = '{1'b0, 2'b01, 1'b1, 32'h11,   32'h0,        1, 1'b1, 32'hFFFFFF80, 4,    32'h11AA8001};
    v[13] = '{1'b1, 2'b10, 1'b0, 32'h12,   32'h0,        1, 1'b1, 32'hFFFFFF80, 4,    32'h11AA8001};
    v[14] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        1, 1'b1, 32'hFFFFFF80, 4,    32'h11AA8001};
    v[15] = '{1'b1, 2'b10, 1'b0, 32'h2000, 32'h55555555, 1, 1'b1, 32'hFFFFFF80, 0,    32'h00000000};
    v[16] = '{1'b1, 2'b10, 1'b0, 32'h1FFC, 32'hA5A5A5A5, 2, 1'b0, 32'hFFFFFF80, 2047, 32'hA5A5A5A5};
    v[17] = '{1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0,        2, 1'b0, 32'hA5A5A5A5, 2047, 32'hA5A5A5A5};
    v[18] = '{1'b1, 2'b00, 1'b0, 32'h1FFC, 32'h0000003C, 3, 1'b0, 32'hA5A5A5A5, 2047, 32'hA5A5A53C};
    v[19] = '{1'b0, 2'b00, 1'b0, 32'h1FFF, 32'h0,        2, 1'b0, 32'h000000A5, 2047, 32'hA5A5A53C};

    rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst valid_err", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst ena_wena", {30'd0, dm_ena, dm_wena}, 32'd0);
    chk("rst dm_addr", {21'd0, dm_addr}, 32'd0);
    chk("rst dm_wdata", dm_wdata, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    rst_n = 1;

    for (int i = 0; i < 20; i++) run(v[i], i);

    // reset during WRITE of a byte store leaves memory untouched
    run('{1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 2, 1'b0, 32'h000000A5, 8, 32'h01020304}, 20);
    req_valid = 1; req_we = 1; req_size = 2'b00; req_signed = 0;
    req_addr = 32'h21; req_wdata = 32'hFF;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rst_mid rmw_ena", {31'd0, dm_ena}, 32'd1);
    @(posedge clk); #1;
    chk("rst_mid wena_before", {31'd0, dm_wena}, 32'd1);
    chk("rst_mid wdata_merged", dm_wdata, 32'h0102FF04);
    rst_n = 0;
    #1;
    chk("rst_mid wena_gated", {31'd0, dm_wena}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst_mid ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid rdata_cleared", resp_rdata, 32'd0);
    chk("rst_mid mem", mem[8], 32'h01020304);

    // busy stall: fields change while busy, second request accepted after DONE
    req_valid = 1; req_we = 0; req_size = 2'b10; req_signed = 0;
    req_addr = 32'h20; req_wdata = 32'h0;
    @(posedge clk); #1;
    chk("stall ready_load", {31'd0, req_ready}, 32'd0);
    chk("stall ena_load", {31'd0, dm_ena}, 32'd1);
    req_we = 1; req_addr = 32'h24; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    chk("stall valid_done", {31'd0, resp_valid}, 32'd1);
    chk("stall rdata", resp_rdata, 32'h01020304);
    chk("stall ready_done", {31'd0, req_ready}, 32'd0);
    req_wdata = 32'h77777777;
    @(posedge clk); #1;
    chk("stall ready_idle", {31'd0, req_ready}, 32'd1);
    chk("stall valid_idle", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 0;
    chk("stall wena", {31'd0, dm_wena}, 32'd1);
    chk("stall wr_addr", {21'd0, dm_addr}, 32'd9);
    chk("stall wr_data", dm_wdata, 32'h77777777);
    @(posedge clk); #1;
    chk("stall valid2", {30'd0, resp_valid, resp_err}, 32'd2);
    @(posedge clk); #1;
    chk("stall ready_end", {31'd0, req_ready}, 32'd1);
    chk("stall mem9", mem[9], 32'h77777777);
    chk("stall mem8", mem[8], 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req_valid  input  1  CPU memory request present.
REQ-005 req_ready  output  1  high only in IDLE; request accepted on a rising edge with req_valid && req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 req_signed  input  1  sign-extend sub-word loads (lb/lh) when 1; zero-extend (lbu/lhu) when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result; valid while resp_valid is high; held otherwise.
REQ-013 resp_err  output  1  qualifies resp_valid; set when the request was rejected.
REQ-014 dm_ena  output  1  data memory enable.
REQ-015 dm_wena  output  1  data memory write enable; memory writes on the falling edge of the cycle in which it is high.
REQ-016 dm_addr  output  11  data memory word address.
REQ-017 dm_wdata  output  32  data memory write word.
REQ-018 dm_rdata  input  32  data memory read word; combinational from dm_addr when dm_ena is high.

Function
REQ-019 States SHALL be IDLE, LOAD, RMW_RD, WRITE and DONE.
REQ-020 On acceptance, the block SHALL latch req_we, req_size, req_signed, req_addr and req_wdata; request inputs SHALL be ignored in all other cycles.
REQ-021 dm_addr SHALL equal latched addr[12:2] in LOAD, RMW_RD and WRITE, and 0 otherwise.
REQ-022 Byte lanes SHALL be little-endian: byte n = bits [8n+7:8n] for addr[1:0]=n; half at addr[1]=0 is [15:0], at addr[1]=1 is [31:16].
REQ-023 Error check at acceptance: a request is rejected if req_size=11, if it is a half with addr[0]=1, if it is a word with addr[1:0]!=0, or if addr[31:13]!=0.
REQ-024 A rejected request SHALL go IDLE->DONE with resp_err=1, SHALL leave resp_rdata unchanged, and SHALL cause no memory access.
REQ-025 A legal load SHALL go IDLE->LOAD->DONE->IDLE; LOAD asserts dm_ena and registers the extracted, extended lane into resp_rdata.
REQ-026 A legal word store SHALL go IDLE->WRITE->DONE->IDLE; in WRITE, dm_wdata equals the latched wdata.
REQ-027 A legal byte or half store SHALL go IDLE->RMW_RD->WRITE->DONE->IDLE.
REQ-028 RMW_RD SHALL register the merged word: dm_rdata with only the target lane replaced by wdata.
REQ-029 In that flow, WRITE SHALL drive the merged word.
REQ-030 dm_ena SHALL be high only in LOAD, RMW_RD and WRITE.
REQ-031 dm_wena SHALL be high only in WRITE, gated combinationally with rst_n.
REQ-032 dm_wdata SHALL be 0 outside WRITE.
REQ-033 resp_valid SHALL be high only in DONE, for exactly one cycle; resp_err SHALL be 0 whenever resp_valid is 0.
REQ-034 Latency from the acceptance edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-035 Back-to-back requests: req_ready SHALL rise the cycle after DONE; no request is accepted in DONE.
REQ-036 resp_rdata SHALL change only in LOAD or on reset.

Reset
REQ-037 With rst_n low at a rising edge, the next state SHALL be IDLE and all latched registers and resp_rdata SHALL be cleared to 0.
REQ-038 With rst_n low in any cycle, dm_wena SHALL be 0 in that cycle, so a store aborted mid-operation SHALL leave memory unmodified.
REQ-039 After reset, outputs SHALL be: req_ready=1; resp_valid, resp_err, dm_ena, dm_wena=0; dm_addr, dm_wdata, resp_rdata=0.

Verification
REQ-040 Word store then load: store addr=0x10, data 0xDEADBEEF -> dm_wena for one cycle with dm_addr=4, resp_valid at +2. Then load word 0x10 -> resp_rdata=0xDEADBEEF at +2.
REQ-041 Sub-word store: memory word 4 = 0x11223344; store byte 0xAA at addr 0x12 -> RMW flow, memory word becomes 0x11AA3344, resp_valid at +3.
REQ-042 Sign extension, memory word 4 = 0x11AA3344 -> lb at 0x12 gives 0xFFFFFFAA; lbu gives 0x000000AA; lh at 0x12 gives 0x000011AA.
REQ-043 Errors: half at 0x11, word at 0x12, size=11, addr=0x2000 -> resp_valid and resp_err at +1, dm_ena never high, memory unchanged.
REQ-044 Reset mid-store: assert rst_n=0 during WRITE of a byte store -> dm_wena=0 that cycle, memory unchanged, state IDLE and req_ready=1 after the edge.
REQ-045 Busy stall: hold req_valid high with changing fields while busy -> only the first request is executed; the next is accepted the cycle after DONE.
